// File: rtl/serial_add_arbiter.sv
// Round-robin front end for one shared bit-serial adder.
// Grants one requester per operation and returns its tagged sum.
module serial_add_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 8,
   parameter int ADD_LAT = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   gnt,
   output logic              rsp_valid,
   output logic [1:0]        rsp_id,
   output logic [W-1:0]      rsp_sum,
   output logic              busy,
   output logic              add_en,
   output logic [W-1:0]      add_a,
   output logic [W-1:0]      add_b,
   input  logic [W-1:0]      add_out
);

   localparam int CW = $clog2(ADD_LAT) + 1;
   localparam logic [CW-1:0] LAST = CW'(ADD_LAT - 1);
   localparam logic [1:0] TOP = 2'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   logic [1:0]    rr_ptr;
   logic [1:0]    cur_id;
   logic [CW-1:0] wait_cnt;

   logic          found;
   logic [1:0]    win;
   logic [1:0]    idx;

   // First set request at or above rr_ptr, wrapping at NREQ-1.
   always_comb begin
      found = 1'b0;
      win   = rr_ptr;
      idx   = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
         idx = 2'((int'(rr_ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         cur_id    <= '0;
         wait_cnt  <= '0;
         gnt       <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
         busy      <= 1'b0;
         add_en    <= 1'b0;
         add_a     <= '0;
         add_b     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (found) begin
                  add_a  <= req_a[win*W +: W];
                  add_b  <= req_b[win*W +: W];
                  cur_id <= win;
                  gnt    <= ONE << win;
                  add_en <= 1'b1;
                  busy   <= 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               gnt      <= '0;
               add_en   <= 1'b0;
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               // Terminal count lands on the edge ending cycle E+ADD_LAT.
               if (wait_cnt == LAST) begin
                  rsp_sum   <= add_out;
                  rsp_id    <= cur_id;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               rr_ptr    <= (cur_id == TOP) ? 2'd0 : cur_id + 2'd1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Scoreboard bench for serial_add_arbiter with a latency-10 adder model.
// Stimulus pushes expected grants/responses; a negedge monitor checks them.
module tb_serial_add_arbiter;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int LAT  = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] req_a = '0;
   logic [NREQ*W-1:0] req_b = '0;
   logic [NREQ-1:0]   gnt;
   logic              rsp_valid;
   logic [1:0]        rsp_id;
   logic [W-1:0]      rsp_sum;
   logic              busy;
   logic              add_en;
   logic [W-1:0]      add_a;
   logic [W-1:0]      add_b;
   logic [W-1:0]      add_out;

   serial_add_arbiter #(.NREQ(NREQ), .W(W), .ADD_LAT(LAT)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_sum(rsp_sum), .busy(busy), .add_en(add_en),
      .add_a(add_a), .add_b(add_b), .add_out(add_out)
   );

   always #5 clk = ~clk;

   // Adder model: output is garbage until LAT cycles after add_en.
   int acnt = 0;
   always @(posedge clk) begin
      if (add_en) acnt <= 1;
      else if (acnt > 0 && acnt < LAT) acnt <= acnt + 1;
   end
   assign add_out = (acnt >= LAT) ? W'(add_a + add_b) : ~W'(add_a + add_b);

   int cycle = 0;
   always @(posedge clk) cycle <= cycle + 1;

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      int         gap;
   } g_t;

   typedef struct {
      int         id;
      logic [7:0] sum;
   } r_t;

   g_t gq[$];
   r_t rq[$];

   int nchk = 0;
   int nerr = 0;
   int last_gnt = 0;

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cycle);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid && |gnt) check("gnt_rsp_overlap", 1, 0);
         if (|gnt) begin
            if (gq.size() == 0) begin
               check("unexpected_gnt", 64'(gnt), 0);
            end else begin
               g_t g;
               g = gq.pop_front();
               check("gnt_id", 64'(gnt), 64'(4'b0001 << g.id));
               check("gnt_add_en", 64'(add_en), 1);
               check("gnt_add_a", 64'(add_a), 64'(g.a));
               check("gnt_add_b", 64'(add_b), 64'(g.b));
               if (g.gap != 0)
                  check("gnt_spacing", 64'(cycle - last_gnt), 64'(g.gap));
               last_gnt = cycle;
            end
         end
         if (rsp_valid) begin
            if (rq.size() == 0) begin
               check("unexpected_rsp", 64'(rsp_id), 64'hFF);
            end else begin
               r_t r;
               r = rq.pop_front();
               check("rsp_id", 64'(rsp_id), 64'(r.id));
               check("rsp_sum", 64'(rsp_sum), 64'(r.sum));
               check("rsp_latency", 64'(cycle - last_gnt), 64'(LAT + 1));
               check("rsp_busy", 64'(busy), 1);
            end
         end
      end
   end

   task automatic cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load(int id, logic [7:0] a, logic [7:0] b);
      req_a[id*W +: W] = a;
      req_b[id*W +: W] = b;
   endtask

   task automatic expect_op(int id, logic [7:0] a, logic [7:0] b,
                            logic [7:0] sum, int gap);
      gq.push_back('{id, a, b, gap});
      rq.push_back('{id, sum});
   endtask

   task automatic single(int id, logic [7:0] a, logic [7:0] b,
                         logic [7:0] sum);
      load(id, a, b);
      expect_op(id, a, b, sum, 0);
      req = 4'b0001 << id;
      cyc(1);
      req = '0;
      cyc(14);
   endtask

   function automatic logic [63:0] all_out();
      return {32'(gnt), 8'(rsp_valid), 8'(rsp_id), rsp_sum,
              8'(busy), 8'(add_en), add_a, add_b};
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset with every requester asking
      load(0, 8'h11, 8'h22);
      load(1, 8'h33, 8'h44);
      req = 4'b1111;
      cyc(1);
      check("reset_outs_a", all_out(), 0);
      cyc(2);
      check("reset_outs_b", {all_out(), 8'(gnt)}, 0);
      req = '0;
      rst = 1'b0;
      cyc(4);
      check("idle_busy", 64'(busy), 0);
      check("idle_gnt", 64'(gnt), 0);

      single(0, 8'h25, 8'h1A, 8'h3F);
      single(2, 8'hF0, 8'h20, 8'h10);
      single(3, 8'h7E, 8'h81, 8'hFF);

      // Round robin from rr_ptr=0, all four requesting
      load(0, 8'h10, 8'h01);
      load(1, 8'h22, 8'h03);
      load(2, 8'h7F, 8'h01);
      load(3, 8'hFF, 8'hFF);
      expect_op(0, 8'h10, 8'h01, 8'h11, 0);
      expect_op(1, 8'h22, 8'h03, 8'h25, 13);
      expect_op(2, 8'h7F, 8'h01, 8'h80, 13);
      expect_op(3, 8'hFF, 8'hFF, 8'hFE, 13);
      expect_op(0, 8'h10, 8'h01, 8'h11, 13);
      req = 4'b1111;
      cyc(53);
      req = '0;
      cyc(14);

      // Operand change during WAIT is ignored
      load(1, 8'h40, 8'h05);
      expect_op(1, 8'h40, 8'h05, 8'h45, 0);
      req = 4'b0010;
      cyc(1);
      req = '0;
      cyc(4);
      load(1, 8'hFF, 8'hFF);
      cyc(12);

      // Requester 1 raises and drops while 0 is served
      load(0, 8'h0C, 8'h30);
      expect_op(0, 8'h0C, 8'h30, 8'h3C, 0);
      req = 4'b0001;
      cyc(1);
      req = '0;
      cyc(3);
      req = 4'b0010;
      cyc(3);
      req = '0;
      cyc(10);

      // Reset five cycles after add_en aborts the operation
      load(2, 8'h33, 8'h44);
      expect_op(2, 8'h33, 8'h44, 8'h77, 0);
      req = 4'b0100;
      cyc(1);
      req = '0;
      cyc(5);
      rst = 1'b1;
      rq.delete(rq.size() - 1);
      #1;
      check("abort_outs", all_out(), 0);
      cyc(2);
      rst = 1'b0;
      cyc(15);
      single(3, 8'h80, 8'h80, 8'h00);

      check("gnt_queue_drained", 64'(gq.size()), 0);
      check("rsp_queue_drained", 64'(rq.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
